// File: rtl/mem_access_ctrl_if.sv
// Memory-side MFA/MFC bus between the access controller and byte-addressed RAM.
interface mem_access_ctrl_if;
    logic        MFA;
    logic [5:0]  mem_opcode;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        MFC;

    modport master (
        output MFA,
        output mem_opcode,
        output mem_address,
        output mem_data_in,
        input  mem_data_out,
        input  MFC
    );

    modport slave (
        input  MFA,
        input  mem_opcode,
        input  mem_address,
        input  mem_data_in,
        output mem_data_out,
        output MFC
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the SPARC data-memory MFA/MFC four-phase handshake.
// Validates requests, splits ldd/std into two word accesses, aborts on timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [5:0]  req_opcode,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [63:0] rdata,
    mem_access_ctrl_if.master mem
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LD   = 6'b001000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STD  = 6'b000111;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        REL,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic          legal;
    logic          is_load;
    logic          is_dbl;
    logic [2:0]    amask;
    logic          misal;

    logic          accept;
    logic          reject;
    logic          ack_hit;
    logic          rel_next;
    logic          rel_end;
    logic          tmo;

    logic [1:0]    mfc_q;
    logic          mfc_s;
    logic [CW-1:0] cnt;

    logic          load_q;
    logic          dbl_q;
    logic          second_q;
    logic [7:0]    addr_q;
    logic [31:0]   wlo_q;
    logic [63:0]   rbuf;

    logic          err_q;
    logic [1:0]    code_q;
    logic [63:0]   rdata_q;
    logic          mfa_q;
    logic [5:0]    op_q;
    logic [7:0]    maddr_q;
    logic [31:0]   mdata_q;

    // amask marks the address bits that must be zero for the access size
    always_comb begin
        legal   = 1'b1;
        is_load = 1'b0;
        is_dbl  = 1'b0;
        amask   = 3'b000;
        case (req_opcode)
            OP_LDSB: is_load = 1'b1;
            OP_LDUB: is_load = 1'b1;
            OP_LDSH: begin is_load = 1'b1; amask = 3'b001; end
            OP_LDUH: begin is_load = 1'b1; amask = 3'b001; end
            OP_LD:   begin is_load = 1'b1; amask = 3'b011; end
            OP_LDD:  begin
                is_load = 1'b1;
                is_dbl  = 1'b1;
                amask   = 3'b111;
            end
            OP_STB:  amask = 3'b000;
            OP_STH:  amask = 3'b001;
            OP_ST:   amask = 3'b011;
            OP_STD:  begin is_dbl = 1'b1; amask = 3'b111; end
            default: legal = 1'b0;
        endcase
        misal = |(req_addr[2:0] & amask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mfc_q <= 2'b00;
        end else begin
            mfc_q <= {mfc_q[0], mem.MFC};
        end
    end

    assign mfc_s = mfc_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        reject   = 1'b0;
        ack_hit  = 1'b0;
        rel_next = 1'b0;
        rel_end  = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (legal && !misal) begin
                        accept  = 1'b1;
                        state_n = ACK;
                    end else begin
                        reject  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            ACK: begin
                if (mfc_s) begin
                    ack_hit = 1'b1;
                    state_n = REL;
                end else if (cnt == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end
            end
            REL: begin
                if (!mfc_s) begin
                    if (dbl_q && !second_q) begin
                        rel_next = 1'b1;
                        state_n  = ACK;
                    end else begin
                        rel_end = 1'b1;
                        state_n = DONE;
                    end
                end else if (cnt == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept || ack_hit || rel_next) begin
            cnt <= '0;
        end else if (state == ACK || state == REL) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Load words land in rbuf and only reach rdata once the whole access
    // completes, so an aborted access leaves the previous result intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= 1'b0;
            dbl_q    <= 1'b0;
            second_q <= 1'b0;
            addr_q   <= '0;
            wlo_q    <= '0;
            rbuf     <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            rdata_q  <= '0;
            mfa_q    <= 1'b0;
            op_q     <= '0;
            maddr_q  <= '0;
            mdata_q  <= '0;
        end else begin
            if (accept) begin
                load_q   <= is_load;
                dbl_q    <= is_dbl;
                second_q <= 1'b0;
                addr_q   <= req_addr;
                wlo_q    <= req_wdata[31:0];
                rbuf     <= '0;
                err_q    <= 1'b0;
                code_q   <= 2'b00;
                mfa_q    <= 1'b1;
                maddr_q  <= req_addr;
                if (is_dbl) begin
                    op_q    <= is_load ? OP_LD : OP_ST;
                    mdata_q <= req_wdata[63:32];
                end else begin
                    op_q    <= req_opcode;
                    mdata_q <= req_wdata[31:0];
                end
            end
            if (reject) begin
                err_q  <= 1'b1;
                code_q <= legal ? 2'b01 : 2'b10;
            end
            if (ack_hit) begin
                mfa_q <= 1'b0;
                if (load_q) begin
                    if (dbl_q && !second_q) begin
                        rbuf[63:32] <= mem.mem_data_out;
                    end else begin
                        rbuf[31:0] <= mem.mem_data_out;
                    end
                end
            end
            if (rel_next) begin
                second_q <= 1'b1;
                maddr_q  <= addr_q + 8'd4;
                mdata_q  <= wlo_q;
                mfa_q    <= 1'b1;
            end
            if (rel_end && load_q) begin
                rdata_q <= rbuf;
            end
            if (tmo) begin
                mfa_q  <= 1'b0;
                err_q  <= 1'b1;
                code_q <= 2'b11;
            end
        end
    end

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign err             = err_q;
    assign err_code        = code_q;
    assign rdata           = rdata_q;
    assign mem.MFA         = mfa_q;
    assign mem.mem_opcode  = op_q;
    assign mem.mem_address = maddr_q;
    assign mem.mem_data_in = mdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural big-endian RAM on the MFA/MFC bus,
// table-driven requests and a scoreboard checked at every done pulse.
module tb_mem_access_ctrl;

    localparam int T = 16;

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic        e;
        logic [1:0]  code;
        logic        chk;
        logic [63:0] rd;
        int          rises;
    } vec_t;

    typedef struct {
        logic        e;
        logic [1:0]  code;
        logic        chk;
        logic [63:0] rd;
        int          rises;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [5:0]  req_opcode;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [63:0] rdata;

    mem_access_ctrl_if mif ();

    mem_access_ctrl #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .rdata      (rdata),
        .mem        (mif)
    );

    int tests = 0;
    int fails = 0;
    int dones = 0;
    int mfa_rises = 0;
    int base = 0;
    int hi_run = 0;
    int last_hi = 0;
    int viol = 0;
    int ram_mode = 0;
    logic prev_mfa = 1'b0;
    logic [45:0] prev_bus = '0;
    exp_t sb[$];
    logic [13:0] acc_log[$];
    logic [7:0] ram[256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge mif.MFA) mfa_rises++;

    // RAM: ram_mode 0 normal, 1 never answers, 2 MFC stuck high after rise
    initial begin
        mif.MFC = 1'b0;
        mif.mem_data_out = '0;
        forever begin
            wait (mif.MFA === 1'b1);
            #3;
            if (ram_mode != 1) begin
                automatic logic [7:0] a = mif.mem_address;
                automatic logic [31:0] d = mif.mem_data_in;
                acc_log.push_back({mif.mem_opcode, a});
                case (mif.mem_opcode)
                    6'b000100: begin
                        ram[a] = d[31:24];
                        ram[8'(a + 1)] = d[23:16];
                        ram[8'(a + 2)] = d[15:8];
                        ram[8'(a + 3)] = d[7:0];
                    end
                    6'b000110: begin
                        ram[a] = d[15:8];
                        ram[8'(a + 1)] = d[7:0];
                    end
                    6'b000101: ram[a] = d[7:0];
                    6'b001000: mif.mem_data_out = {ram[a], ram[8'(a + 1)],
                        ram[8'(a + 2)], ram[8'(a + 3)]};
                    6'b000001: mif.mem_data_out = {24'd0, ram[a]};
                    6'b001001: mif.mem_data_out = {{24{ram[a][7]}}, ram[a]};
                    6'b000010: mif.mem_data_out = {16'd0, ram[a], ram[8'(a + 1)]};
                    6'b001010: mif.mem_data_out = {{16{ram[a][7]}}, ram[a],
                        ram[8'(a + 1)]};
                    default: mif.mem_data_out = 32'hBAD0BAD0;
                endcase
                mif.MFC = 1'b1;
            end
            wait (mif.MFA === 1'b0);
            #3;
            if (ram_mode == 2) wait (ram_mode != 2);
            mif.MFC = 1'b0;
        end
    end

    // Monitor: bus stability, MFA high-time, scoreboard at each done
    always @(negedge clk) begin
        if (!rst_n) begin
            base = mfa_rises;
            hi_run = 0;
            prev_mfa = 1'b0;
        end else begin
            if (mif.MFA) hi_run++;
            else begin
                if (hi_run != 0) last_hi = hi_run;
                hi_run = 0;
            end
            if (mif.MFA && prev_mfa && prev_bus !=
                {mif.mem_opcode, mif.mem_address, mif.mem_data_in})
                viol++;
            prev_mfa = mif.MFA;
            prev_bus = {mif.mem_opcode, mif.mem_address, mif.mem_data_in};
            if (done) begin
                dones++;
                chk("sb_nonempty_at_done", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    automatic exp_t x = sb.pop_front();
                    chk("err", 64'(err), 64'(x.e));
                    chk("err_code", 64'(err_code), 64'(x.code));
                    chk("mfa_rises", 64'(mfa_rises - base), 64'(x.rises));
                    if (x.chk) chk("rdata", rdata, x.rd);
                end
                base = mfa_rises;
            end
        end
    end

    function automatic vec_t mk(logic [5:0] op, logic [7:0] addr,
                                logic [63:0] wd, logic e, logic [1:0] code,
                                logic c, logic [63:0] rd, int rises);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd;
        v.e = e; v.code = code; v.chk = c; v.rd = rd; v.rises = rises;
        return v;
    endfunction

    task automatic drive_req(logic [5:0] op, logic [7:0] addr, logic [63:0] wd);
        req = 1'b1;
        req_opcode = op;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_done(int d0);
        int c = 0;
        while (dones == d0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("done_within_budget", 64'(dones - d0), 1);
    endtask

    task automatic issue(vec_t v);
        exp_t x;
        int d0;
        x.e = v.e; x.code = v.code; x.chk = v.chk; x.rd = v.rd; x.rises = v.rises;
        sb.push_back(x);
        d0 = dones;
        drive_req(v.op, v.addr, v.wdata);
        wait_done(d0);
    endtask

    vec_t tbl[13];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        tbl[0]  = mk(6'b000100, 8'h10, 64'hDEADBEEF, 0, 2'b00, 0, 0, 1);
        tbl[1]  = mk(6'b001000, 8'h10, 0, 0, 2'b00, 1, 64'hDEADBEEF, 1);
        tbl[2]  = mk(6'b000101, 8'h05, 64'h80, 0, 2'b00, 0, 0, 1);
        tbl[3]  = mk(6'b001001, 8'h05, 0, 0, 2'b00, 1, 64'hFFFFFF80, 1);
        tbl[4]  = mk(6'b000001, 8'h05, 0, 0, 2'b00, 1, 64'h80, 1);
        tbl[5]  = mk(6'b111111, 8'h03, 0, 1, 2'b10, 1, 64'h80, 0);
        tbl[6]  = mk(6'b000010, 8'h13, 0, 1, 2'b01, 1, 64'h80, 0);
        tbl[7]  = mk(6'b000011, 8'h04, 0, 1, 2'b01, 0, 0, 0);
        tbl[8]  = mk(6'b000100, 8'h02, 0, 1, 2'b01, 0, 0, 0);
        tbl[9]  = mk(6'b000110, 8'h32, 64'hA5B6, 0, 2'b00, 0, 0, 1);
        tbl[10] = mk(6'b000010, 8'h32, 0, 0, 2'b00, 1, 64'hA5B6, 1);
        tbl[11] = mk(6'b001010, 8'h32, 0, 0, 2'b00, 1, 64'hFFFFA5B6, 1);
        tbl[12] = mk(6'b111111, 8'h00, 0, 1, 2'b10, 0, 0, 0);

        rst_n = 1'b0;
        req = 1'b0;
        req_opcode = '0;
        req_addr = '0;
        req_wdata = '0;
        #12;
        chk("reset_ctrl", 64'({busy, done, err, err_code, mif.MFA}), 0);
        chk("reset_bus", 64'({mif.mem_opcode, mif.mem_address}), 0);
        chk("reset_wdata", 64'(mif.mem_data_in), 0);
        chk("reset_rdata", rdata, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) issue(tbl[i]);

        // std splits into two st accesses at addr and addr+4
        acc_log.delete();
        issue(mk(6'b000111, 8'h20, 64'h1122334455667788, 0, 2'b00, 0, 0, 2));
        chk("std_accesses", 64'(acc_log.size()), 2);
        if (acc_log.size() == 2) begin
            chk("std_first", 64'(acc_log[0]), 64'({6'b000100, 8'h20}));
            chk("std_second", 64'(acc_log[1]), 64'({6'b000100, 8'h24}));
        end
        issue(mk(6'b000011, 8'h20, 0, 0, 2'b00, 1, 64'h1122334455667788, 2));
        issue(mk(6'b000111, 8'hF8, 64'hCAFEBABE01234567, 0, 2'b00, 0, 0, 2));
        issue(mk(6'b000011, 8'hF8, 0, 0, 2'b00, 1, 64'hCAFEBABE01234567, 2));

        // timeout while waiting for MFC to rise
        ram_mode = 1;
        issue(mk(6'b001000, 8'h00, 0, 1, 2'b11, 1, 64'hCAFEBABE01234567, 1));
        chk("ack_timeout_mfa_cycles", 64'(last_hi), 64'(T));
        ram_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        // timeout while waiting for MFC to fall
        ram_mode = 2;
        issue(mk(6'b001000, 8'h00, 0, 1, 2'b11, 1, 64'hCAFEBABE01234567, 1));
        ram_mode = 0;
        repeat (5) @(posedge clk);
        #1;

        // asynchronous reset in the middle of an access
        ram_mode = 1;
        drive_req(6'b001000, 8'h40, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mfa", 64'(mif.MFA), 0);
        chk("async_reset_busy_done", 64'({busy, done}), 0);
        #2;
        rst_n = 1'b1;
        ram_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        issue(mk(6'b000100, 8'h40, 64'h600DF00D, 0, 2'b00, 0, 0, 1));
        issue(mk(6'b001000, 8'h40, 0, 0, 2'b00, 1, 64'h600DF00D, 1));

        // a req while busy is dropped
        begin
            exp_t x;
            int d0;
            x.e = 0; x.code = 2'b00; x.chk = 0; x.rd = 0; x.rises = 1;
            sb.push_back(x);
            d0 = dones;
            drive_req(6'b000100, 8'h48, 64'h12345678);
            @(posedge clk);
            #1;
            drive_req(6'b001000, 8'h00, 0);
            wait_done(d0);
            repeat (20) @(posedge clk);
            #1;
            chk("no_extra_done", 64'(dones - d0), 1);
        end
        issue(mk(6'b001000, 8'h48, 0, 0, 2'b00, 1, 64'h12345678, 1));

        chk("bus_stable_while_mfa", 64'(viol), 0);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the SPARC data-memory MFA/MFC handshake. Accepts one load/store request at a time from the datapath and drives MFA, opcode, address and write data to the byte-addressed RAM. Waits for MFC using a full four-phase handshake and returns load data. Checks alignment and opcode legality, splits ldd/std into two word accesses, and aborts on a handshake timeout.

Parameters:
TIMEOUT, 64, max clk cycles spent waiting in either handshake phase before aborting (>=4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request strobe; sampled only in IDLE
req_opcode  in  6  SPARC ld/st op3 code (table below)
req_addr  in  8  byte address
req_wdata  in  64  store data; bits [31:0] for stb/sth/st, {word@addr, word@addr+4} for std
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse (success or error)
err  out  1  valid with done; 1 = request failed
err_code  out  2  00 ok, 01 misaligned, 10 illegal opcode, 11 timeout; held until next accept
rdata  out  64  load result; {32'b0, word} for single loads, {word@addr, word@addr+4} for ldd
MFA  out  1  memory function active, to RAM
mem_opcode  out  6  opcode to RAM
mem_address  out  8  address to RAM
mem_data_in  out  32  write data to RAM DataIn
mem_data_out  in  32  RAM DataOut, stable while MFC high
MFC  in  1  memory function complete; asynchronous to clk

Behaviour:
- Opcodes: ldsb 001001, ldsh 001010, ld 001000, ldub 000001, lduh 000010, ldd 000011, stb 000101, sth 000110, st 000100, std 000111. Any other value is illegal.
- Alignment: half-word ops need addr[0]=0. ld/st need addr[1:0]=0. ldd/std need addr[2:0]=0. Byte ops are always aligned.
- Reset: all outputs 0, rdata 0, state IDLE. A reset mid-operation drops MFA immediately (asynchronously) and discards the request.
- MFC passes through a 2-flop synchronizer (mfc_s). All FSM decisions use mfc_s.
- FSM states: IDLE, ACK, REL, DONE.
- IDLE: on req=1 at a clk edge:
  - If the opcode is illegal or the address is misaligned: go to DONE with err=1 and the matching err_code. MFA is never asserted. Illegal opcode takes priority over misaligned.
  - Otherwise: latch the request, drive mem_opcode/mem_address/mem_data_in, assert MFA, go to ACK. ldd/std issue mem_opcode ld/st (001000/000100) with word 0 data first.
- mem_opcode, mem_address and mem_data_in stay stable from the MFA rise until MFA falls.
- ACK: MFA=1. On mfc_s=1: for loads, capture mem_data_out into the current word slot; drop MFA; go to REL.
- REL: MFA=0. On mfc_s=0:
  - If a double access is on its first word: set mem_address = addr+4, select the second data word, reassert MFA, go to ACK.
  - Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, err as set, then IDLE. busy falls in the same cycle done falls.
- Timeout: the cycle counter clears on every ACK/REL entry. If it reaches TIMEOUT in either state: MFA=0, err_code 11, err=1, go to DONE. rdata is not updated by the aborted access.
- Best-case latency for a single access with immediate MFC: MFA rises 1 cycle after req, with ~6 cycles to done.
- req while busy is ignored and not queued.
- Sign/zero extension is done by the RAM; rdata[31:0] is the RAM word verbatim.
- Address arithmetic is 8-bit. addr+4 cannot wrap for 8-aligned doubles (max 0xF8 -> 0xFC).

Test Plan:
1. st 0xDEADBEEF @0x10, then ld @0x10 against a behavioural RAM -> rdata 0x00000000DEADBEEF; single done pulse with err=0; exactly one MFA rise/fall per access.
2. std 0x1122334455667788 @0x20 -> two MFA pulses, opcode 000100, addresses 0x20 then 0x24; then ldd @0x20 -> rdata 0x1122334455667788.
3. lduh @0x13 -> done with err=1, err_code 01, MFA never high. Opcode 111111 @0x00 -> err_code 10. ldd @0x04 -> err_code 01.
4. MFC tied low, ld @0x00 -> MFA high for TIMEOUT cycles, then MFA=0 and done with err_code 11. Repeat with MFC stuck high after rising -> timeout from REL.
5. rst_n pulsed low during ACK -> MFA, busy and done drop to 0 immediately. After release, st/ld to 0x40 completes correctly.
6. stb 0x80 @0x05, then ldsb @0x05 -> rdata 0x00000000FFFFFF80. A req pulse issued mid-transaction produces no extra MFA pulse.
